// File: rtl/atto.sv
// atto: bufferless 2D-mesh router tile.
// Inputs North/East/PE, outputs South/West/PE-eject. Two-stage pipeline:
// token-detect + capture, then route/arbitrate + output register load.
// North/East are never stalled (losers deflect); PE injection waits for a free output.
module atto (
    input  logic        clka,
    input  logic        rsta,
    input  logic [47:0] north_channel_din,
    input  logic [1:0]  north_diff_pair_din,
    input  logic [47:0] east_channel_din,
    input  logic [1:0]  east_diff_pair_din,
    input  logic [47:0] pe_channel_din,
    input  logic [1:0]  pe_diff_pair_din,
    output logic [47:0] south_channel_dout,
    output logic [1:0]  south_diff_pair_dout,
    output logic [47:0] west_channel_dout,
    output logic [1:0]  west_diff_pair_dout,
    output logic [39:0] pe_channel_dout,
    output logic [1:0]  pe_diff_pair_dout,
    output logic        r2pe_ack_dout
);

    typedef enum logic [1:0] {OUT_S = 2'd0, OUT_W = 2'd1, OUT_P = 2'd2} out_e;

    // Port index: 0 = North, 1 = East, 2 = PE
    logic [2:0][47:0] din;
    logic [2:0][1:0]  pair_in;
    assign din     = {pe_channel_din, east_channel_din, north_channel_din};
    assign pair_in = {pe_diff_pair_din, east_diff_pair_din, north_diff_pair_din};

    logic [2:0][1:0]  seen_q, seen_d;
    logic [2:0][47:0] flit_q, flit_d;
    logic [2:0]       pend_q, pend_d, tog;
    logic [47:0]      south_q, south_d, west_q, west_d;
    logic [39:0]      pe_q, pe_d;
    logic [1:0]       south_pair_q, south_pair_d, west_pair_q, west_pair_d, pe_pair_q, pe_pair_d;
    logic             ack_q, ack_d;

    out_e n_want, e_want, p_want, n_out, e_out;
    logic n_defl, e_defl, s_busy, w_busy, p_busy, pe_grant;

    // North prefers Y first; East and PE prefer X first.
    function automatic out_e route(input logic [47:0] f, input logic y_first);
        logic x_nz, y_nz;
        x_nz = |f[47:44];
        y_nz = |f[43:40];
        if (y_first) return y_nz ? OUT_S : (x_nz ? OUT_W : OUT_P);
        return x_nz ? OUT_W : (y_nz ? OUT_S : OUT_P);
    endfunction

    function automatic logic [47:0] dec_x(input logic [47:0] f);
        return {f[47:44] - 4'd1, f[43:0]};
    endfunction

    function automatic logic [47:0] dec_y(input logic [47:0] f);
        return {f[47:44], f[43:40] - 4'd1, f[39:0]};
    endfunction

    // Token detection and stage-1 capture; PE tokens are dropped while a PE flit waits
    always_comb begin
        seen_d = seen_q;
        flit_d = flit_q;
        pend_d = pend_q;
        tog    = '0;
        for (int i = 0; i < 3; i++) begin
            if (pair_in[i] == 2'b10 || pair_in[i] == 2'b01) begin
                tog[i]    = (pair_in[i] != seen_q[i]);
                seen_d[i] = pair_in[i];
            end
        end
        // North/East are always drained the cycle after capture
        pend_d[0] = tog[0];
        pend_d[1] = tog[1];
        if (tog[0]) flit_d[0] = din[0];
        if (tog[1]) flit_d[1] = din[1];
        if (tog[2] && !pend_q[2]) begin
            pend_d[2] = 1'b1;
            flit_d[2] = din[2];
        end else if (pe_grant) begin
            pend_d[2] = 1'b0;
        end
    end

    // Route and arbitrate; a North/East loser deflects to its straight-through output
    always_comb begin
        n_want   = route(flit_q[0], 1'b1);
        e_want   = route(flit_q[1], 1'b0);
        p_want   = route(flit_q[2], 1'b0);
        n_out    = n_want;
        e_out    = e_want;
        n_defl   = 1'b0;
        e_defl   = 1'b0;
        pe_grant = 1'b0;
        if (pend_q[0] && pend_q[1] && n_want == e_want) begin
            // West goes to East first; South and PE go to North first
            if (n_want == OUT_W) begin
                n_out  = OUT_S;
                n_defl = 1'b1;
            end else begin
                e_out  = OUT_W;
                e_defl = 1'b1;
            end
        end
        s_busy = (pend_q[0] && n_out == OUT_S) || (pend_q[1] && e_out == OUT_S);
        w_busy = (pend_q[0] && n_out == OUT_W) || (pend_q[1] && e_out == OUT_W);
        p_busy = (pend_q[0] && n_out == OUT_P) || (pend_q[1] && e_out == OUT_P);
        case (p_want)
            OUT_S:   pe_grant = pend_q[2] && !s_busy;
            OUT_W:   pe_grant = pend_q[2] && !w_busy;
            OUT_P:   pe_grant = pend_q[2] && !p_busy;
            default: pe_grant = 1'b0;
        endcase
    end

    // Stage-2 output load; routed hops decrement, deflected flits keep their header
    always_comb begin
        south_d      = south_q;
        west_d       = west_q;
        pe_d         = pe_q;
        south_pair_d = south_pair_q;
        west_pair_d  = west_pair_q;
        pe_pair_d    = pe_pair_q;
        ack_d        = pe_grant;
        if (s_busy || (pe_grant && p_want == OUT_S)) begin
            south_pair_d = ~south_pair_q;
            if (pend_q[0] && n_out == OUT_S)      south_d = n_defl ? flit_q[0] : dec_y(flit_q[0]);
            else if (pend_q[1] && e_out == OUT_S) south_d = e_defl ? flit_q[1] : dec_y(flit_q[1]);
            else                                  south_d = dec_y(flit_q[2]);
        end
        if (w_busy || (pe_grant && p_want == OUT_W)) begin
            west_pair_d = ~west_pair_q;
            if (pend_q[1] && e_out == OUT_W)      west_d = e_defl ? flit_q[1] : dec_x(flit_q[1]);
            else if (pend_q[0] && n_out == OUT_W) west_d = n_defl ? flit_q[0] : dec_x(flit_q[0]);
            else                                  west_d = dec_x(flit_q[2]);
        end
        if (p_busy || (pe_grant && p_want == OUT_P)) begin
            pe_pair_d = ~pe_pair_q;
            if (pend_q[0] && n_out == OUT_P)      pe_d = flit_q[0][39:0];
            else if (pend_q[1] && e_out == OUT_P) pe_d = flit_q[1][39:0];
            else                                  pe_d = flit_q[2][39:0];
        end
    end

    // State registers; reset discards in-flight flits
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            seen_q       <= {3{2'b10}};
            flit_q       <= '0;
            pend_q       <= '0;
            south_q      <= '0;
            west_q       <= '0;
            pe_q         <= '0;
            south_pair_q <= 2'b10;
            west_pair_q  <= 2'b10;
            pe_pair_q    <= 2'b10;
            ack_q        <= 1'b0;
        end else begin
            seen_q       <= seen_d;
            flit_q       <= flit_d;
            pend_q       <= pend_d;
            south_q      <= south_d;
            west_q       <= west_d;
            pe_q         <= pe_d;
            south_pair_q <= south_pair_d;
            west_pair_q  <= west_pair_d;
            pe_pair_q    <= pe_pair_d;
            ack_q        <= ack_d;
        end
    end

    assign south_channel_dout   = south_q;
    assign south_diff_pair_dout = south_pair_q;
    assign west_channel_dout    = west_q;
    assign west_diff_pair_dout  = west_pair_q;
    assign pe_channel_dout      = pe_q;
    assign pe_diff_pair_dout    = pe_pair_q;
    assign r2pe_ack_dout        = ack_q;

endmodule

// File: tb/tb_atto.sv
// Testbench for atto: directed scenarios plus random traffic against a
// priority-list reference model of the router.
module tb_atto;

    logic        clka = 1'b0;
    logic        rsta = 1'b0;
    logic [47:0] north_channel_din, east_channel_din, pe_channel_din;
    logic [1:0]  north_diff_pair_din, east_diff_pair_din, pe_diff_pair_din;
    logic [47:0] south_channel_dout, west_channel_dout;
    logic [39:0] pe_channel_dout;
    logic [1:0]  south_diff_pair_dout, west_diff_pair_dout, pe_diff_pair_dout;
    logic        r2pe_ack_dout;

    always #5 clka = ~clka;

    atto dut (
        .clka                 (clka),
        .rsta                 (rsta),
        .north_channel_din    (north_channel_din),
        .north_diff_pair_din  (north_diff_pair_din),
        .east_channel_din     (east_channel_din),
        .east_diff_pair_din   (east_diff_pair_din),
        .pe_channel_din       (pe_channel_din),
        .pe_diff_pair_din     (pe_diff_pair_din),
        .south_channel_dout   (south_channel_dout),
        .south_diff_pair_dout (south_diff_pair_dout),
        .west_channel_dout    (west_channel_dout),
        .west_diff_pair_dout  (west_diff_pair_dout),
        .pe_channel_dout      (pe_channel_dout),
        .pe_diff_pair_dout    (pe_diff_pair_dout),
        .r2pe_ack_dout        (r2pe_ack_dout)
    );

    int vectors = 0;
    int miscompares = 0;

    // Driven-side state: last legal code per port, current data/pair
    logic [1:0]  lp [3];
    logic [1:0]  pr [3];
    logic [47:0] dv [3];

    // Reference model state
    logic [1:0]  m_seen [3];
    logic        m_pend [3];
    logic [47:0] m_flit [3];
    logic [47:0] e_s, e_w;
    logic [39:0] e_p;
    logic [1:0]  e_sp, e_wp, e_pp;
    logic        e_ack;

    task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Desired output: 0 = South, 1 = West, 2 = PE
    function automatic int want(input int s, input logic [47:0] f);
        int x, y;
        x = int'(f[47:44]);
        y = int'(f[43:40]);
        if (s == 0) return (y != 0) ? 0 : ((x != 0) ? 1 : 2);
        return (x != 0) ? 1 : ((y != 0) ? 0 : 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_seen[i] = 2'b10;
            m_pend[i] = 1'b0;
            m_flit[i] = '0;
        end
        e_s = '0; e_w = '0; e_p = '0;
        e_sp = 2'b10; e_wp = 2'b10; e_pp = 2'b10;
        e_ack = 1'b0;
    endtask

    // One rising edge of the reference model
    task automatic model_step();
        int own [3];
        bit defl [3];
        bit done [3];
        int w [3];
        int s, o;
        bit old_pe, pe_g, legal, tg;
        logic [47:0] f;
        for (int i = 0; i < 3; i++) begin
            w[i] = want(i, m_flit[i]);
            own[i] = -1;
            defl[i] = 0;
            done[i] = 0;
        end
        // Outputs in turn take the highest-priority North/East flit asking for them
        for (int oo = 0; oo < 3; oo++) begin
            for (int k = 0; k < 2; k++) begin
                s = (oo == 1) ? (1 - k) : k;
                if (m_pend[s] && !done[s] && own[oo] < 0 && w[s] == oo) begin
                    own[oo] = s; done[s] = 1;
                end
            end
        end
        // Unserved North/East flits take whichever of South/West is left
        for (int k = 0; k < 2; k++) begin
            if (m_pend[k] && !done[k]) begin
                o = (own[1] < 0) ? 1 : 0;
                own[o] = k; defl[o] = 1; done[k] = 1;
            end
        end
        pe_g = m_pend[2] && (own[w[2]] < 0);
        if (pe_g) own[w[2]] = 2;
        if (own[0] >= 0) begin
            f = m_flit[own[0]];
            if (!defl[0]) f[43:40] = f[43:40] - 4'd1;
            e_s = f; e_sp = ~e_sp;
        end
        if (own[1] >= 0) begin
            f = m_flit[own[1]];
            if (!defl[1]) f[47:44] = f[47:44] - 4'd1;
            e_w = f; e_wp = ~e_wp;
        end
        if (own[2] >= 0) begin
            f = m_flit[own[2]];
            e_p = f[39:0]; e_pp = ~e_pp;
        end
        e_ack = pe_g;
        old_pe = m_pend[2];
        for (int i = 0; i < 3; i++) begin
            legal = (pr[i] == 2'b10 || pr[i] == 2'b01);
            tg = legal && (pr[i] != m_seen[i]);
            if (legal) m_seen[i] = pr[i];
            if (i < 2) begin
                m_pend[i] = tg;
                if (tg) m_flit[i] = dv[i];
            end else if (tg && !old_pe) begin
                m_pend[2] = 1'b1;
                m_flit[2] = dv[2];
            end else if (pe_g) begin
                m_pend[2] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        chk("south_data", south_channel_dout, e_s);
        chk("south_pair", {46'd0, south_diff_pair_dout}, {46'd0, e_sp});
        chk("west_data", west_channel_dout, e_w);
        chk("west_pair", {46'd0, west_diff_pair_dout}, {46'd0, e_wp});
        chk("pe_data", {8'd0, pe_channel_dout}, {8'd0, e_p});
        chk("pe_pair", {46'd0, pe_diff_pair_dout}, {46'd0, e_pp});
        chk("ack", {47'd0, r2pe_ack_dout}, {47'd0, e_ack});
    endtask

    task automatic drive();
        north_channel_din = dv[0]; north_diff_pair_din = pr[0];
        east_channel_din  = dv[1]; east_diff_pair_din  = pr[1];
        pe_channel_din    = dv[2]; pe_diff_pair_din    = pr[2];
    endtask

    task automatic cycle();
        @(posedge clka);
        model_step();
        #1;
        check_all();
    endtask

    // Drive one cycle of inputs; a set toggle bit sends a new flit on that port
    task automatic apply(input bit nt, input logic [47:0] nd, input bit et, input logic [47:0] ed,
                         input bit pt, input logic [47:0] pd);
        if (nt) begin dv[0] = nd; lp[0] = ~lp[0]; end
        if (et) begin dv[1] = ed; lp[1] = ~lp[1]; end
        if (pt) begin dv[2] = pd; lp[2] = ~lp[2]; end
        for (int i = 0; i < 3; i++) pr[i] = lp[i];
        drive();
        cycle();
    endtask

    function automatic logic [47:0] rnd_flit();
        logic [3:0] x, y;
        x = 4'($urandom_range(0, 3));
        y = 4'($urandom_range(0, 3));
        return {x, y, $urandom(), 8'($urandom())};
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            lp[i] = 2'b10; pr[i] = 2'b10; dv[i] = '0;
        end
        drive();
        model_reset();
        repeat (2) @(posedge clka);
        #1 check_all();
        @(negedge clka);
        rsta = 1'b1;
        repeat (3) apply(0, 0, 0, 0, 0, 0);

        // North routes South, Y decremented
        apply(1, 48'h210000000000, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("n_south", south_channel_dout, 48'h200000000000);
        chk("n_south_pair", {46'd0, south_diff_pair_dout}, {46'd0, 2'b01});

        // East routes West, X decremented
        apply(0, 0, 1, 48'h121111111111, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("e_west", west_channel_dout, 48'h021111111111);
        chk("e_west_pair", {46'd0, west_diff_pair_dout}, {46'd0, 2'b01});

        // PE injection with ack
        apply(0, 0, 0, 0, 1, 48'h333333333333);
        apply(0, 0, 0, 0, 0, 0);
        chk("pe_ack", {47'd0, r2pe_ack_dout}, 48'd1);
        chk("pe_west", west_channel_dout, 48'h233333333333);
        apply(0, 0, 0, 0, 0, 0);
        chk("pe_ack_drop", {47'd0, r2pe_ack_dout}, 48'd0);

        // Simultaneous North and East to different outputs
        apply(1, 48'h120000000000, 1, 48'h121111111111, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("sim_south", south_channel_dout, 48'h110000000000);
        chk("sim_west", west_channel_dout, 48'h021111111111);

        // North ejects to PE, East goes West
        apply(1, 48'h000000000ABC, 1, 48'h101111111111, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("ej_pe", {8'd0, pe_channel_dout}, 48'h000000000ABC);
        chk("ej_west", west_channel_dout, 48'h001111111111);

        // Both want South: North wins, East deflected West unchanged
        apply(1, 48'h010000000001, 1, 48'h010000000002, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("cf_south", south_channel_dout, 48'h000000000001);
        chk("cf_west", west_channel_dout, 48'h010000000002);

        // PE held while East occupies West
        apply(0, 0, 1, 48'h100000000011, 1, 48'h100000000005);
        apply(0, 0, 1, 48'h100000000022, 0, 0);
        chk("hold_ack0", {47'd0, r2pe_ack_dout}, 48'd0);
        apply(0, 0, 1, 48'h100000000033, 0, 0);
        chk("hold_ack1", {47'd0, r2pe_ack_dout}, 48'd0);
        apply(0, 0, 0, 0, 0, 0);
        chk("hold_ack2", {47'd0, r2pe_ack_dout}, 48'd0);
        apply(0, 0, 0, 0, 0, 0);
        chk("hold_grant", {47'd0, r2pe_ack_dout}, 48'd1);
        chk("hold_west", west_channel_dout, 48'h000000000005);

        // Random traffic with illegal pair codes and one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 3; p++) begin
                int a;
                a = int'($urandom_range(0, 9));
                if (a < 5 && (p < 2 || !m_pend[2])) begin
                    lp[p] = ~lp[p];
                    dv[p] = rnd_flit();
                    pr[p] = lp[p];
                end else if (a == 9) begin
                    pr[p] = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
                end else begin
                    pr[p] = lp[p];
                end
            end
            drive();
            cycle();
            if (c == 1500) begin
                #2 rsta = 1'b0;
                #1 model_reset();
                check_all();
                @(negedge clka);
                rsta = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
